lod_rr_arbiter: RTL



---
 rtl/lod_rr_arbiter_if.sv | 38 +++
 rtl/lod_rr_arbiter.sv | 88 ++++++++
 2 files changed

// File: rtl/lod_rr_arbiter_if.sv
// lod_rr_arbiter_if
//   Handshake bundle between the mantissa producers / normalizer and the
//   shared leading-one-detector arbiter.
//   Ports (slave view = arbiter side):
//     req_valid    in   NumReq        per-requester operand valid
//     req_data     in   NumReq*Width  operands, requester i at [i*Width +: Width]
//     req_ready    out  NumReq        one-hot grant / accept strobe (or zero)
//     rsp_valid    out  1             response buffer holds a result
//     rsp_ready    in   1             consumer accepts the response
//     rsp_id       out  IdWidth       requester that produced the result
//     rsp_position out  PosWidth      bit index of the most significant 1
//     rsp_has_one  out  1             operand contained at least one 1
interface lod_rr_arbiter_if #(
   parameter int NumReq = 4,
   parameter int Width  = 12
);
   localparam int PosWidth = $clog2(Width);
   localparam int IdWidth  = $clog2(NumReq);

   logic [NumReq-1:0]       req_valid;
   logic [NumReq*Width-1:0] req_data;
   logic [NumReq-1:0]       req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [IdWidth-1:0]      rsp_id;
   logic [PosWidth-1:0]     rsp_position;
   logic                    rsp_has_one;

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_position, rsp_has_one
   );

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_position, rsp_has_one
   );
endinterface

// File: rtl/lod_rr_arbiter.sv
// lod_rr_arbiter
//   Round-robin arbiter sharing one leading-one detector among NumReq
//   requesters. One requester is granted per cycle while the single-entry
//   response buffer is free (empty or draining); the granted operand passes
//   through the combinational detector straight into the buffer.
//   Ports:
//     clk  in  sole clock, rising edge
//     rst  in  synchronous active-high reset
//     bus  lod_rr_arbiter_if.slave  request/response handshake bundle
module lod_rr_arbiter #(
   parameter int NumReq = 4,
   parameter int Width  = 12
) (
   input  logic             clk,
   input  logic             rst,
   lod_rr_arbiter_if.slave  bus
);
   localparam int PosWidth = $clog2(Width);
   localparam int IdWidth  = $clog2(NumReq);

   // Index of the most significant 1; a zero operand yields 0.
   function automatic logic [PosWidth-1:0] lod_position(input logic [Width-1:0] x);
      logic [PosWidth-1:0] pos;
      pos = '0;
      for (int i = 0; i < Width; i++) begin
         if (x[i]) pos = PosWidth'(i);
      end
      return pos;
   endfunction

   logic                vld_p1;
   logic [IdWidth-1:0]  id_p1;
   logic [PosWidth-1:0] pos_p1;
   logic                has_one_p1;
   logic [IdWidth-1:0]  last_p1;

   logic                buf_free;
   logic                grant_found;
   logic [IdWidth-1:0]  grant_idx;
   logic                transfer;
   logic [Width-1:0]    grant_data;
   int                  scan_idx;

   // Search last+1, last+2, ... wrapping; the first valid index wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 1; k <= NumReq; k++) begin
         scan_idx = (int'(last_p1) + k) % NumReq;
         if (!grant_found && bus.req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = IdWidth'(scan_idx);
         end
      end
   end

   assign buf_free   = !vld_p1 || bus.rsp_ready;
   // rst suppresses the grant so a reset cycle neither drains nor accepts.
   assign transfer   = !rst && buf_free && grant_found;
   assign grant_data = bus.req_data[grant_idx*Width +: Width];

   assign bus.req_ready = transfer ? (NumReq'(1) << grant_idx) : '0;

   // Stage p0 -> p1: detector output registered into the response buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1     <= 1'b0;
         id_p1      <= '0;
         pos_p1     <= '0;
         has_one_p1 <= 1'b0;
         last_p1    <= IdWidth'(NumReq - 1);
      end else if (transfer) begin
         vld_p1     <= 1'b1;
         id_p1      <= grant_idx;
         pos_p1     <= lod_position(grant_data);
         has_one_p1 <= |grant_data;
         last_p1    <= grant_idx;
      end else if (bus.rsp_ready) begin
         vld_p1     <= 1'b0;
      end
   end

   assign bus.rsp_valid    = vld_p1;
   assign bus.rsp_id       = id_p1;
   assign bus.rsp_position = pos_p1;
   assign bus.rsp_has_one  = has_one_p1;
endmodule
